// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and field helpers for the fetch/decode front end.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_BLTZ   = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FUNC_JR   = 6'b001000;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;

    localparam logic [31:0] BUBBLE_WORD = 32'h0000_0000;

    function automatic logic [4:0] rs_of(input logic [31:0] w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] w);
        return w[20:16];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and pipeline-history signals between fetch_unit and its neighbours.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] rs_value_ex;
    logic [31:0] instruction;
    logic [31:0] ex_int_forward;
    logic [31:0] mem_int_forward;
    logic [31:0] pc_id;
    logic [31:0] pc_ex;
    logic        stall;
    logic        flush;

    modport master (
        output imem_addr, instruction, ex_int_forward, mem_int_forward, pc_id, pc_ex,
               stall, flush,
        input  imem_data, rs_value_ex
    );

    modport slave (
        input  imem_addr, instruction, ex_int_forward, mem_int_forward, pc_id, pc_ex,
               stall, flush,
        output imem_data, rs_value_ex
    );
endinterface

// File: rtl/hazard_detect.sv
// Decodes the EX instruction for j/jr/bltz redirects and detects lw-use hazards against ID.
module hazard_detect
    import mips_pkg::*;
(
    input  logic [31:0] i_ex_instr,
    input  logic [31:0] i_id_instr,
    input  logic [31:0] i_pc_ex,
    input  logic [31:0] i_rs_value_ex,
    output logic        o_stall,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc
);
    logic [5:0]  w_ex_op;
    logic [5:0]  w_ex_func;
    logic [4:0]  w_ex_rt;
    logic [31:0] w_pc_ex4;
    logic [31:0] w_br_off;
    logic        w_is_j;
    logic        w_is_jr;
    logic        w_is_bltz;
    logic        w_is_lw;
    logic        w_unused_id;

    assign w_ex_op   = i_ex_instr[31:26];
    assign w_ex_func = i_ex_instr[5:0];
    assign w_ex_rt   = rt_of(i_ex_instr);
    assign w_pc_ex4  = i_pc_ex + 32'd4;
    assign w_br_off  = {{14{i_ex_instr[15]}}, i_ex_instr[15:0], 2'b00};

    assign w_is_j    = (w_ex_op == OP_J);
    assign w_is_jr   = (w_ex_op == OP_RTYPE) && (w_ex_func == FUNC_JR);
    assign w_is_bltz = (w_ex_op == OP_BLTZ);
    assign w_is_lw   = (w_ex_op == OP_LW);

    // Only the register fields of the ID word matter for hazard detection.
    assign w_unused_id = ^{i_id_instr[31:26], i_id_instr[15:0]};

    assign o_stall = w_is_lw && (w_ex_rt != 5'd0) &&
                     ((w_ex_rt == rs_of(i_id_instr)) || (w_ex_rt == rt_of(i_id_instr)));

    always_comb begin
        o_flush       = 1'b0;
        o_redirect_pc = w_pc_ex4;
        if (w_is_j) begin
            o_flush       = 1'b1;
            o_redirect_pc = {w_pc_ex4[31:28], i_ex_instr[25:0], 2'b00};
        end else if (w_is_jr) begin
            o_flush       = 1'b1;
            o_redirect_pc = i_rs_value_ex;
        end else if (w_is_bltz && i_rs_value_ex[31]) begin
            o_flush       = 1'b1;
            o_redirect_pc = w_pc_ex4 + w_br_off;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Owns the PC and the ID/EX/MEM instruction history; resolves EX redirects and load-use bubbles.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = BUBBLE_WORD
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    logic [31:0] r_pc;
    logic [31:0] r_id;
    logic [31:0] r_ex;
    logic [31:0] r_mem;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc_ex;
    logic        w_stall;
    logic        w_flush;
    logic [31:0] w_redirect_pc;

    hazard_detect u_hazard_detect (
        .i_ex_instr    (r_ex),
        .i_id_instr    (r_id),
        .i_pc_ex       (r_pc_ex),
        .i_rs_value_ex (bus.rs_value_ex),
        .o_stall       (w_stall),
        .o_flush       (w_flush),
        .o_redirect_pc (w_redirect_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_id    <= BUBBLE;
            r_ex    <= BUBBLE;
            r_mem   <= BUBBLE;
            r_pc_id <= 32'd0;
            r_pc_ex <= 32'd0;
        end else if (w_flush) begin
            // No delay slot: both younger slots are wrong-path and die here.
            r_pc    <= w_redirect_pc;
            r_id    <= BUBBLE;
            r_pc_id <= 32'd0;
            r_ex    <= BUBBLE;
            r_pc_ex <= 32'd0;
            r_mem   <= r_ex;
        end else if (w_stall) begin
            r_ex    <= BUBBLE;
            r_pc_ex <= 32'd0;
            r_mem   <= r_ex;
        end else begin
            r_pc    <= r_pc + 32'd4;
            r_id    <= bus.imem_data;
            r_pc_id <= r_pc;
            r_ex    <= r_id;
            r_pc_ex <= r_pc_id;
            r_mem   <= r_ex;
        end
    end

    assign bus.imem_addr       = r_pc;
    assign bus.instruction     = r_id;
    assign bus.ex_int_forward  = r_ex;
    assign bus.mem_int_forward = r_mem;
    assign bus.pc_id           = r_pc_id;
    assign bus.pc_ex           = r_pc_ex;
    assign bus.stall           = w_stall;
    assign bus.flush           = w_flush;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors, corner sequences and a random model run.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    fetch_unit_if ifc ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUBBLE   (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign ifc.imem_data = mem[ifc.imem_addr[11:2]];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    // Instruction encoders
    function automatic logic [31:0] e_j(input logic [25:0] f);
        return {6'b000010, f};
    endfunction
    function automatic logic [31:0] e_jr(input logic [4:0] rs);
        return {6'b000000, rs, 15'b0, 6'b001000};
    endfunction
    function automatic logic [31:0] e_bltz(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {6'b000001, rs, rt, imm};
    endfunction
    function automatic logic [31:0] e_lw(input logic [4:0] rt, input logic [4:0] rs);
        return {6'b100011, rs, rt, 16'h0004};
    endfunction
    function automatic logic [31:0] e_sw(input logic [4:0] rt, input logic [4:0] rs);
        return {6'b101011, rs, rt, 16'h0008};
    endfunction
    function automatic logic [31:0] e_addi(input logic [4:0] rt, input logic [4:0] rs,
                                           input logic [15:0] imm);
        return {6'b001000, rs, rt, imm};
    endfunction
    function automatic logic [31:0] e_subu(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'b0, 6'b100011};
    endfunction

    // Reference model state (behavioural view of the pipeline)
    logic [31:0] m_pc, m_id, m_ex, m_mem, m_pc_id, m_pc_ex;
    bit          m_pc_ex_known;

    task automatic model_reset();
        m_pc = 0; m_id = 0; m_ex = 0; m_mem = 0; m_pc_id = 0; m_pc_ex = 0;
        m_pc_ex_known = 1;
    endtask

    task automatic model_eval(input logic [31:0] rsv, output bit st, output bit fl,
                              output logic [31:0] tgt);
        int unsigned op, fn, ex_rt, id_rs, id_rt;
        int off;
        op    = m_ex >> 26;
        fn    = m_ex & 32'h3F;
        ex_rt = (m_ex >> 16) & 32'h1F;
        id_rs = (m_id >> 21) & 32'h1F;
        id_rt = (m_id >> 16) & 32'h1F;
        st  = (op == 35) && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        fl  = 0;
        tgt = 0;
        if (op == 2) begin
            fl  = 1;
            tgt = ((m_pc_ex + 4) & 32'hF000_0000) | ((m_ex & 32'h03FF_FFFF) * 4);
        end else if (op == 0 && fn == 8) begin
            fl  = 1;
            tgt = rsv;
        end else if (op == 1 && rsv[31]) begin
            fl  = 1;
            off = int'($signed(m_ex[15:0])) * 4;
            tgt = m_pc_ex + 4 + 32'(off);
        end
    endtask

    task automatic model_step(input bit r, input logic [31:0] rsv);
        bit st, fl;
        logic [31:0] tgt;
        model_eval(rsv, st, fl, tgt);
        if (r) model_reset();
        else if (fl) begin
            m_mem = m_ex; m_ex = 0; m_id = 0; m_pc_id = 0; m_pc = tgt; m_pc_ex_known = 0;
        end else if (st) begin
            m_mem = m_ex; m_ex = 0; m_pc_ex_known = 0;
        end else begin
            m_mem = m_ex; m_ex = m_id; m_pc_ex = m_pc_id; m_pc_ex_known = 1;
            m_id = mem[m_pc[11:2]]; m_pc_id = m_pc; m_pc = m_pc + 4;
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] ex_w;
        logic [31:0] id_w;
        logic [31:0] rsv;
        logic        exp_stall;
        logic        exp_flush;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs [14];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit st, fl;
        logic [31:0] tgt, rsv;
        bit rr;
        int unsigned k;

        ifc.rs_value_ex = 32'h0;

        // Older word lands in EX (pc_ex = 0) and younger in ID two cycles after reset.
        vecs[0]  = '{"j_0x40",      e_j(26'h40), e_subu(1, 2, 3), 32'h0,         0, 1, 32'h100};
        vecs[1]  = '{"jr_0x400",    e_jr(3), e_subu(1, 2, 3), 32'h400,           0, 1, 32'h400};
        vecs[2]  = '{"bltz_back",   e_bltz(2, 0, 16'hFFFE), 32'h0, 32'h8000_0000, 0, 1, 32'hFFFF_FFFC};
        vecs[3]  = '{"bltz_fwd",    e_bltz(2, 0, 16'h0010), 32'h0, 32'h8000_0001, 0, 1, 32'h44};
        vecs[4]  = '{"bltz_nt",     e_bltz(2, 0, 16'h0010), 32'h0, 32'h1,         0, 0, 32'hC};
        vecs[5]  = '{"bltz_rt_ign", e_bltz(2, 5, 16'h0003), 32'h0, 32'hFFFF_FFFF, 0, 1, 32'h10};
        vecs[6]  = '{"lu_rs",       e_lw(5, 0), e_subu(1, 5, 2), 32'h0,           1, 0, 32'h8};
        vecs[7]  = '{"lu_rt",       e_lw(5, 0), e_subu(1, 2, 5), 32'h0,           1, 0, 32'h8};
        vecs[8]  = '{"lu_r0",       e_lw(0, 1), e_subu(1, 0, 0), 32'h0,           0, 0, 32'hC};
        vecs[9]  = '{"lu_nomatch",  e_lw(5, 0), e_subu(1, 6, 7), 32'h0,           0, 0, 32'hC};
        vecs[10] = '{"sw_nostall",  e_sw(5, 0), e_subu(1, 5, 2), 32'h0,           0, 0, 32'hC};
        vecs[11] = '{"addi_nojr",   e_addi(5, 0, 16'h0008), e_subu(1, 5, 2), 32'h8000_0000,
                     0, 0, 32'hC};
        vecs[12] = '{"lu_addi_rt",  e_lw(9, 0), e_addi(9, 1, 16'h1), 32'h0,       1, 0, 32'h8};
        vecs[13] = '{"jr_odd",      e_jr(4), 32'h0, 32'h3,                        0, 1, 32'h3};

        // Reset state
        clear_mem();
        reset_dut();
        chk("rst_addr", ifc.imem_addr, 32'h0);
        chk("rst_id", ifc.instruction, 32'h0);
        chk("rst_ex", ifc.ex_int_forward, 32'h0);
        chk("rst_mem", ifc.mem_int_forward, 32'h0);
        chk("rst_pc_id", ifc.pc_id, 32'h0);
        chk("rst_pc_ex", ifc.pc_ex, 32'h0);
        chk("rst_stall", ifc.stall, 1'b0);
        chk("rst_flush", ifc.flush, 1'b0);

        // Table-driven EX/ID pairs
        for (int v = 0; v < 14; v++) begin
            clear_mem();
            mem[0] = vecs[v].ex_w;
            mem[1] = vecs[v].id_w;
            ifc.rs_value_ex = vecs[v].rsv;
            reset_dut();
            cyc();
            cyc();
            chk({vecs[v].name, "_stall"}, ifc.stall, vecs[v].exp_stall);
            chk({vecs[v].name, "_flush"}, ifc.flush, vecs[v].exp_flush);
            cyc();
            chk({vecs[v].name, "_next"}, ifc.imem_addr, vecs[v].exp_next);
        end

        // Straight-line fetch and 3-cycle latency to MEM
        clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = e_addi(5'(i + 1), 0, 16'(i + 16'h100));
        ifc.rs_value_ex = 32'h0;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", ifc.imem_addr, 32'(4 * i));
            if (i == 3) chk("seq_mem_lat", ifc.mem_int_forward, mem[0]);
            cyc();
        end

        // j at 0x10, field 0x40
        clear_mem();
        for (int i = 0; i < 7; i++) mem[i] = e_addi(1, 0, 16'(i + 16'h50));
        mem[4]    = e_j(26'h40);
        mem['h40] = e_addi(2, 0, 16'h1234);
        reset_dut();
        for (int i = 0; i < 6; i++) cyc();
        chk("j_flush", ifc.flush, 1'b1);
        chk("j_id_wrong", ifc.instruction, mem[5]);
        cyc();
        chk("j_addr", ifc.imem_addr, 32'h100);
        chk("j_id_bub", ifc.instruction, 32'h0);
        chk("j_ex_bub", ifc.ex_int_forward, 32'h0);
        chk("j_mem", ifc.mem_int_forward, mem[4]);
        cyc();
        chk("j_id_tgt", ifc.instruction, mem['h40]);
        chk("j_pc_id", ifc.pc_id, 32'h100);
        chk("j_0x14_dead", ifc.mem_int_forward, 32'h0);

        // bltz at 0x20, imm 0xFFFE, taken then not taken
        clear_mem();
        for (int i = 0; i < 12; i++) mem[i] = e_addi(1, 0, 16'(i));
        mem[8] = e_bltz(2, 0, 16'hFFFE);
        ifc.rs_value_ex = 32'h8000_0000;
        reset_dut();
        for (int i = 0; i < 10; i++) cyc();
        chk("bltz_t_flush", ifc.flush, 1'b1);
        cyc();
        chk("bltz_t_addr", ifc.imem_addr, 32'h1C);
        ifc.rs_value_ex = 32'h1;
        reset_dut();
        for (int i = 0; i < 10; i++) cyc();
        chk("bltz_nt_flush", ifc.flush, 1'b0);
        cyc();
        chk("bltz_nt_addr", ifc.imem_addr, 32'h2C);

        // Load-use stall lasts one cycle
        clear_mem();
        mem[0] = e_lw(5, 0);
        mem[1] = e_subu(6, 5, 7);
        mem[2] = e_addi(3, 0, 16'h77);
        ifc.rs_value_ex = 32'h0;
        reset_dut();
        cyc();
        cyc();
        chk("lu_stall", ifc.stall, 1'b1);
        cyc();
        chk("lu_stall_gone", ifc.stall, 1'b0);
        chk("lu_pc_hold", ifc.imem_addr, 32'h8);
        chk("lu_id_hold", ifc.instruction, mem[1]);
        chk("lu_ex_bub", ifc.ex_int_forward, 32'h0);
        chk("lu_mem", ifc.mem_int_forward, mem[0]);
        cyc();
        chk("lu_adv_addr", ifc.imem_addr, 32'hC);
        chk("lu_adv_ex", ifc.ex_int_forward, mem[1]);
        chk("lu_adv_id", ifc.instruction, mem[2]);

        // Reset asserted on the stall edge
        reset_dut();
        cyc();
        cyc();
        chk("rs_stall", ifc.stall, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rs_addr", ifc.imem_addr, 32'h0);
        chk("rs_id", ifc.instruction, 32'h0);
        chk("rs_ex", ifc.ex_int_forward, 32'h0);
        chk("rs_mem", ifc.mem_int_forward, 32'h0);
        chk("rs_stall_clr", ifc.stall, 1'b0);

        // PC wrap from 0xFFFF_FFFC
        clear_mem();
        mem[0] = e_jr(1);
        ifc.rs_value_ex = 32'hFFFF_FFFC;
        reset_dut();
        cyc();
        cyc();
        chk("wrap_flush", ifc.flush, 1'b1);
        cyc();
        chk("wrap_top", ifc.imem_addr, 32'hFFFF_FFFC);
        ifc.rs_value_ex = 32'h0;
        cyc();
        chk("wrap_zero", ifc.imem_addr, 32'h0);

        // Random program vs. reference model
        for (int i = 0; i < 1024; i++) begin
            k = $urandom_range(0, 99);
            if (k < 10)      mem[i] = e_j(26'($urandom));
            else if (k < 18) mem[i] = e_jr(5'($urandom_range(0, 3)));
            else if (k < 30) mem[i] = e_bltz(5'($urandom_range(0, 3)), 5'($urandom),
                                             16'($urandom));
            else if (k < 55) mem[i] = e_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            else if (k < 80) mem[i] = e_subu(5'($urandom_range(0, 3)),
                                             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            else             mem[i] = e_addi(5'($urandom_range(0, 3)),
                                             5'($urandom_range(0, 3)), 16'($urandom));
        end
        reset_dut();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rsv = $urandom();
            if ($urandom_range(0, 3) == 0) rsv = {rsv[31], 19'b0, rsv[11:2], 2'b00};
            rr  = ($urandom_range(0, 99) == 0);
            ifc.rs_value_ex = rsv;
            rst = rr;
            @(negedge clk);
            model_eval(rsv, st, fl, tgt);
            chk("rnd_addr", ifc.imem_addr, m_pc);
            chk("rnd_id", ifc.instruction, m_id);
            chk("rnd_ex", ifc.ex_int_forward, m_ex);
            chk("rnd_mem", ifc.mem_int_forward, m_mem);
            chk("rnd_pc_id", ifc.pc_id, m_pc_id);
            if (m_pc_ex_known) chk("rnd_pc_ex", ifc.pc_ex, m_pc_ex);
            chk("rnd_stall", ifc.stall, st);
            chk("rnd_flush", ifc.flush, fl);
            @(posedge clk);
            model_step(rr, rsv);
            #1;
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
